// File: rtl/icache_if.sv
// Fetch-side and memory-side handshake signals of the instruction cache.
interface icache_if;
    localparam int unsigned WORD_W = 32;

    logic              imemREN;
    logic [WORD_W-1:0] imemaddr;
    logic              ihit;
    logic [WORD_W-1:0] imemload;
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, two-word lines, combinational hits,
// two-beat block fill from memory on a miss.
module icache #(
    parameter int unsigned IDX_W = 3
) (
    input logic     CLK,
    input logic     nRST,
    icache_if.slave bus
);
    localparam int unsigned SETS  = 2 ** IDX_W;
    localparam int unsigned TAG_W = 29 - IDX_W;

    typedef enum logic [1:0] {IDLE, FETCH0, FETCH1} state_t;

    state_t state, next_state;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tag_arr   [SETS];
    logic [31:0]      word0_arr [SETS];
    logic [31:0]      word1_arr [SETS];

    logic [31:0] fill_addr, fill_addr_nxt;
    logic [31:0] buf_word0;
    logic        load_word0_c;
    logic        commit_c;
    logic        hit_c;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic             req_off;
    logic [TAG_W-1:0] fill_tag;
    logic [IDX_W-1:0] fill_idx;
    logic             unused_byte_off;

    assign req_tag         = bus.imemaddr[31:IDX_W+3];
    assign req_idx         = bus.imemaddr[IDX_W+2:3];
    assign req_off         = bus.imemaddr[2];
    assign fill_tag        = fill_addr[31:IDX_W+3];
    assign fill_idx        = fill_addr[IDX_W+2:3];
    assign unused_byte_off = ^bus.imemaddr[1:0];

    // Next-state and fetch/memory port outputs
    always_comb begin
        next_state    = state;
        fill_addr_nxt = fill_addr;
        load_word0_c  = 1'b0;
        commit_c      = 1'b0;
        hit_c         = 1'b0;
        bus.ihit      = 1'b0;
        bus.imemload  = 32'd0;
        bus.iREN      = 1'b0;
        bus.iaddr     = 32'd0;
        case (state)
            IDLE: begin
                hit_c = bus.imemREN && valid[req_idx] && (tag_arr[req_idx] == req_tag);
                if (hit_c) begin
                    bus.ihit     = 1'b1;
                    bus.imemload = req_off ? word1_arr[req_idx] : word0_arr[req_idx];
                end else if (bus.imemREN) begin
                    fill_addr_nxt = {bus.imemaddr[31:3], 3'b000};
                    next_state    = FETCH0;
                end
            end
            FETCH0: begin
                bus.iREN  = 1'b1;
                bus.iaddr = fill_addr;
                if (!bus.iwait) begin
                    load_word0_c = 1'b1;
                    next_state   = FETCH1;
                end
            end
            FETCH1: begin
                bus.iREN  = 1'b1;
                bus.iaddr = fill_addr + 32'd4;
                if (!bus.iwait) begin
                    commit_c   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Control state; valid bits are the only array state that is reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            valid     <= '0;
            fill_addr <= 32'd0;
        end else begin
            state     <= next_state;
            fill_addr <= fill_addr_nxt;
            if (commit_c) valid[fill_idx] <= 1'b1;
        end
    end

    // Line is written in one edge so it is never seen half-filled
    always_ff @(posedge CLK) begin
        if (load_word0_c) buf_word0 <= bus.iload;
        if (commit_c) begin
            tag_arr[fill_idx]   <= fill_tag;
            word0_arr[fill_idx] <= buf_word0;
            word1_arr[fill_idx] <= bus.iload;
        end
    end
endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: expected fetch data queued at request, popped on ihit.
module tb_icache;
    logic CLK;
    logic nRST;

    icache_if bus();

    icache #(.IDX_W(3)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int wait_cfg = 0;

    logic [31:0] sb_q[$];
    logic [31:0] trace_q[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0) return 32'h11111111;
        if (a == 32'h4) return 32'h22222222;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Memory: combinational data, wait_cfg busy cycles per word address
    assign bus.iload = mem_fn(bus.iaddr);

    logic [31:0] cur_addr;
    bit          active = 0;
    int          wcnt = 0;
    always @(negedge CLK) begin
        if (bus.iREN) begin
            if (!active || bus.iaddr != cur_addr) begin
                active   = 1;
                cur_addr = bus.iaddr;
                wcnt     = 0;
            end
            bus.iwait = (wcnt < wait_cfg);
            wcnt++;
        end else begin
            active    = 0;
            bus.iwait = 1'b0;
        end
    end

    // Monitor: scoreboard pop on every hit, idle-zero rules otherwise
    always @(negedge CLK) begin
        if (bus.ihit === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_hit: imemaddr=%h imemload=%h with empty scoreboard", bus.imemaddr, bus.imemload);
            end else begin
                logic [31:0] exp;
                exp = sb_q.pop_front();
                if (bus.imemload !== exp) begin
                    errors++;
                    $display("FAIL hit_data: addr=%h got %h want %h", bus.imemaddr, bus.imemload, exp);
                end
            end
        end else begin
            checks++;
            if (bus.imemload !== 32'd0) begin
                errors++;
                $display("FAIL imemload_idle: got %h want 0", bus.imemload);
            end
        end
        if (bus.iREN !== 1'b1) begin
            checks++;
            if (bus.iaddr !== 32'd0) begin
                errors++;
                $display("FAIL iaddr_idle: got %h want 0", bus.iaddr);
            end
        end
    end

    // Present one fetch, return cycles until ihit and record memory addresses seen
    task automatic fetch(input logic [31:0] addr, output int lat);
        bit done;
        done = 0;
        @(posedge CLK); #1;
        sb_q.push_back(mem_fn({addr[31:2], 2'b00}));
        trace_q.delete();
        bus.imemREN  = 1'b1;
        bus.imemaddr = addr;
        lat = 0;
        while (!done && lat < 64) begin
            @(negedge CLK); #1;
            if (bus.ihit === 1'b1) done = 1;
            else begin
                if (bus.iREN === 1'b1) trace_q.push_back(bus.iaddr);
                lat++;
            end
        end
        bus.imemREN = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: addr=%h no ihit within %0d cycles", addr, lat);
            void'(sb_q.pop_front());
            lat = -1;
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h4;
        #12;
        checks++;
        if (bus.ihit !== 1'b0 || bus.imemload !== 32'd0 || bus.iREN !== 1'b0 || bus.iaddr !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: ihit=%b imemload=%h iREN=%b iaddr=%h want all 0",
                     bus.ihit, bus.imemload, bus.iREN, bus.iaddr);
        end
        bus.imemREN = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
    endtask

    task automatic test_cold_miss();
        int lat;
        fetch(32'h4, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL cold_miss_latency: got %0d want 3", lat);
        end
        checks++;
        if (trace_q.size() != 2 || trace_q[0] !== 32'h0 || trace_q[1] !== 32'h4) begin
            errors++;
            $display("FAIL cold_miss_iaddr: got %0d beats first=%h want 0x0,0x4",
                     trace_q.size(), trace_q.size() > 0 ? trace_q[0] : 32'hx);
        end
    endtask

    task automatic test_same_block_hit();
        int lat;
        fetch(32'h0, lat);
        checks++;
        if (lat !== 0 || trace_q.size() != 0) begin
            errors++;
            $display("FAIL same_block_hit: latency %0d beats %0d want 0/0", lat, trace_q.size());
        end
        fetch(32'h4, lat);
        checks++;
        if (lat !== 0) begin
            errors++;
            $display("FAIL back_to_back_hit: latency %0d want 0", lat);
        end
    endtask

    task automatic test_conflict();
        int lat;
        fetch(32'h40, lat);
        checks++;
        if (lat !== 3 || trace_q.size() != 2 || trace_q[0] !== 32'h40 || trace_q[1] !== 32'h44) begin
            errors++;
            $display("FAIL conflict_fill: latency %0d beats %0d want 3 with 0x40,0x44", lat, trace_q.size());
        end
        fetch(32'h0, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL conflict_evict: re-access 0x0 latency %0d want 3", lat);
        end
    endtask

    task automatic test_wait_states();
        int lat;
        bit addr_ok;
        wait_cfg = 3;
        fetch(32'h208, lat);
        wait_cfg = 0;
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL wait_latency: got %0d want 9", lat);
        end
        addr_ok = (trace_q.size() == 8);
        for (int i = 0; i < trace_q.size() && i < 8; i++)
            if (trace_q[i] !== (i < 4 ? 32'h208 : 32'h20C)) addr_ok = 0;
        checks++;
        if (!addr_ok) begin
            errors++;
            $display("FAIL wait_iaddr_hold: got %0d beats want 4x0x208 then 4x0x20c", trace_q.size());
        end
    endtask

    task automatic test_withdrawn();
        int lat;
        logic [31:0] a0, a1;
        @(posedge CLK); #1;
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h300;
        @(posedge CLK); #1;
        bus.imemREN  = 1'b0;
        bus.imemaddr = 32'h100;
        @(negedge CLK); #1;
        a0 = bus.iaddr;
        @(negedge CLK); #1;
        a1 = bus.iaddr;
        checks++;
        if (a0 !== 32'h300 || a1 !== 32'h304) begin
            errors++;
            $display("FAIL withdrawn_fill_addr: got %h,%h want 300,304", a0, a1);
        end
        @(negedge CLK); #1;
        checks++;
        if (bus.iREN !== 1'b0 || bus.ihit !== 1'b0) begin
            errors++;
            $display("FAIL withdrawn_return_idle: iREN=%b ihit=%b want 0/0", bus.iREN, bus.ihit);
        end
        fetch(32'h300, lat);
        checks++;
        if (lat !== 0) begin
            errors++;
            $display("FAIL withdrawn_orig_hit: latency %0d want 0", lat);
        end
        fetch(32'h100, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL withdrawn_new_miss: latency %0d want 3", lat);
        end
    endtask

    task automatic test_reset_mid_fill();
        int lat;
        fetch(32'h0, lat);
        fetch(32'h0, lat);
        checks++;
        if (lat !== 0) begin
            errors++;
            $display("FAIL pre_reset_line_valid: latency %0d want 0", lat);
        end
        @(posedge CLK); #1;
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h48;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        checks++;
        if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h4C) begin
            errors++;
            $display("FAIL mid_fill_fetch1: iREN=%b iaddr=%h want 1/4c", bus.iREN, bus.iaddr);
        end
        nRST = 1'b0;
        bus.imemREN = 1'b0;
        #1;
        checks++;
        if (bus.iREN !== 1'b0 || bus.iaddr !== 32'd0) begin
            errors++;
            $display("FAIL reset_async_iren: iREN=%b iaddr=%h want 0/0", bus.iREN, bus.iaddr);
        end
        @(posedge CLK); #1;
        nRST = 1'b1;
        fetch(32'h0, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL reset_invalidates: 0x0 latency %0d want 3", lat);
        end
        fetch(32'h48, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL abandoned_fill_invalid: 0x48 latency %0d want 3", lat);
        end
    endtask

    initial begin
        bus.imemREN  = 1'b0;
        bus.imemaddr = 32'd0;
        test_reset();
        test_cold_miss();
        test_same_block_hit();
        test_conflict();
        test_wait_states();
        test_withdrawn();
        test_reset_mid_fill();
        repeat (2) @(posedge CLK);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
